// File: rtl/spi_master.sv
// SPI mode-0 bus master: MSB-first serdes with programmable SCLK divider and burst nCS hold.
// Optional SPI_MASTER_LATE_SAMPLE_EN moves MISO sampling to the last clk of each SCLK-high phase.
module spi_master #(
  parameter int n   = 8,
  parameter int div = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [n-1:0] in,
  input  logic         clki,
  input  logic         cont,
  output logic [n-1:0] out,
  output logic         clko,
  output logic         busy,
  output logic         MOSI,
  input  logic         MISO,
  output logic         SCLK,
  output logic         nCS
);

  localparam int BIT_W = $clog2(n + 1);
  localparam int DIV_W = $clog2(div + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TAIL,
    S_WAIT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [n-1:0]     tx_q, tx_d;
  logic [n-1:0]     rx_q, rx_d;
  logic [n-1:0]     out_q, out_d;
  logic             cont_q, cont_d;
  logic             sclk_q, sclk_d;
  logic             ncs_q, ncs_d;
  logic             busy_q, busy_d;
  logic             clko_q, clko_d;

  logic phase_end;
  logic accept;
  logic sample;

  assign phase_end = (div_cnt_q == DIV_W'(div - 1));
  assign accept    = clki && (state_q == S_IDLE || state_q == S_WAIT);

`ifdef SPI_MASTER_LATE_SAMPLE_EN
  assign sample = (state_q == S_HIGH) && phase_end;
`else
  assign sample = (state_q == S_LEAD || state_q == S_LOW) && phase_end;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    out_d     = out_q;
    cont_d    = cont_q;
    sclk_d    = sclk_q;
    ncs_d     = ncs_q;
    busy_d    = busy_q;
    clko_d    = 1'b0;

    // Timed phases restart the divider on every phase boundary.
    if (state_q inside {S_LEAD, S_HIGH, S_LOW, S_TAIL, S_GAP})
      div_cnt_d = phase_end ? '0 : div_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        if (!clki && !cont) begin
          ncs_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_LEAD, S_LOW: begin
        if (phase_end) begin
          state_d   = S_HIGH;
          sclk_d    = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == BIT_W'(n)) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_LOW;
            tx_d    = {tx_q[n-2:0], 1'b0};
          end
        end
      end
      S_TAIL: begin
        if (phase_end) begin
          clko_d = 1'b1;
          out_d  = rx_q;
          if (cont_q) begin
            state_d = S_WAIT;
            busy_d  = 1'b0;
          end else begin
            state_d = S_GAP;
            ncs_d   = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (phase_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sample)
      rx_d = {rx_q[n-2:0], MISO};

    // A burst continuation from WAIT starts exactly like a fresh word, minus the nCS edge.
    if (accept) begin
      state_d   = S_LEAD;
      tx_d      = in;
      cont_d    = cont;
      busy_d    = 1'b1;
      ncs_d     = 1'b0;
      rx_d      = '0;
      bit_cnt_d = '0;
      div_cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      out_q     <= '0;
      cont_q    <= 1'b0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      busy_q    <= 1'b0;
      clko_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      out_q     <= out_d;
      cont_q    <= cont_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      busy_q    <= busy_d;
      clko_q    <= clko_d;
    end
  end

  assign out  = out_q;
  assign clko = clko_q;
  assign busy = busy_q;
  assign MOSI = tx_q[n-1];
  assign SCLK = sclk_q;
  assign nCS  = ncs_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: 8-bit/div=2 instance with a mode-0 slave model,
// 16-bit/div=1 instance in loopback (delayed loopback when SPI_MASTER_LATE_SAMPLE_EN is set).
module tb_spi_master;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instance A: n=8, div=2
  logic [7:0] in_a = '0, out_a;
  logic clki_a = 1'b0, cont_a = 1'b0;
  logic clko_a, busy_a, mosi_a, miso_a, sclk_a, ncs_a;

  spi_master #(.n(8), .div(2)) u_a (
    .clk(clk), .nrst(nrst), .in(in_a), .clki(clki_a), .cont(cont_a),
    .out(out_a), .clko(clko_a), .busy(busy_a), .MOSI(mosi_a), .MISO(miso_a),
    .SCLK(sclk_a), .nCS(ncs_a)
  );

  // Instance B: n=16, div=1
  logic [15:0] in_b = '0, out_b;
  logic clki_b = 1'b0, cont_b = 1'b0;
  logic clko_b, busy_b, mosi_b, miso_b, sclk_b, ncs_b;
  logic mosi_b_d = 1'b0;

  spi_master #(.n(16), .div(1)) u_b (
    .clk(clk), .nrst(nrst), .in(in_b), .clki(clki_b), .cont(cont_b),
    .out(out_b), .clko(clko_b), .busy(busy_b), .MOSI(mosi_b), .MISO(miso_b),
    .SCLK(sclk_b), .nCS(ncs_b)
  );

  always @(posedge clk) mosi_b_d <= mosi_b;
`ifdef SPI_MASTER_LATE_SAMPLE_EN
  assign miso_b = mosi_b_d;
`else
  assign miso_b = mosi_b;
`endif

  // Mode-0 slave for instance A: first bit on nCS fall, shifts on SCLK fall, reloads every 8 bits.
  logic [7:0] resp_q[$];
  logic [7:0] slv_tx = '0;
  logic [7:0] slv_rx = '0;
  int scnt = 0;
  assign miso_a = slv_tx[7];

  always @(negedge ncs_a) begin
    scnt = 0;
    if (resp_q.size() > 0) slv_tx = resp_q.pop_front();
    else slv_tx = '0;
  end
  always @(posedge ncs_a) scnt = 0;
  always @(posedge sclk_a) if (!ncs_a) slv_rx = {slv_rx[6:0], mosi_a};
  always @(negedge sclk_a) begin
    if (!ncs_a) begin
      scnt++;
      if (scnt == 8) begin
        scnt = 0;
        if (resp_q.size() > 0) slv_tx = resp_q.pop_front();
        else slv_tx = '0;
      end else begin
        slv_tx = slv_tx << 1;
      end
    end
  end

  // SCLK rise and nCS rise tracking on instance A
  int rise_q[$];
  int ncs_rise_cnt = 0;
  logic sclk_prev = 1'b0, ncs_prev = 1'b1;
  always @(posedge clk) begin
    #1;
    if (sclk_a && !sclk_prev) rise_q.push_back(cyc);
    if (ncs_a && !ncs_prev) ncs_rise_cnt++;
    sclk_prev = sclk_a;
    ncs_prev  = ncs_a;
  end

  // Scoreboards
  typedef struct {
    logic [15:0] data;
    logic [7:0]  mosi;
    int          cyc;
  } exp_t;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];
  int clko_cnt_a = 0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (clko_a) begin
      clko_cnt_a++;
      if (exp_q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_clko: got clko=1 expected none (cycle %0d, out=%0h)", cyc, out_a);
      end else begin
        e = exp_q_a.pop_front();
        check("a_out", out_a, e.data);
        check("a_mosi_bits", slv_rx, e.mosi);
        check("a_clko_cycle", cyc, e.cyc);
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (clko_b) begin
      if (exp_q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_clko: got clko=1 expected none (cycle %0d, out=%0h)", cyc, out_b);
      end else begin
        e = exp_q_b.pop_front();
        check("b_out", out_b, e.data);
        check("b_clko_cycle", cyc, e.cyc);
      end
    end
  end

  // Drivers
  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_a(input logic [7:0] d, input logic c, output int t0);
    @(negedge clk);
    in_a   = d;
    cont_a = c;
    clki_a = 1'b1;
    @(posedge clk);
    #1;
    t0     = cyc;
    clki_a = 1'b0;
  endtask

  task automatic start_b(input logic [15:0] d, output int t0);
    @(negedge clk);
    in_b   = d;
    cont_b = 1'b0;
    clki_b = 1'b1;
    @(posedge clk);
    #1;
    t0     = cyc;
    clki_b = 1'b0;
  endtask

  task automatic pulse_a_ignored(input int at_edge);
    wait_cyc(at_edge - 1);
    @(negedge clk);
    in_a   = 8'hFF;
    clki_a = 1'b1;
    @(posedge clk);
    #1;
    clki_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, nr0, c0, guard;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ncs", ncs_a, 1'b1);
    check("rst_sclk", sclk_a, 1'b0);
    check("rst_mosi", mosi_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_out", out_a, 8'h00);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single word A5, slave returns 3C
    resp_q.push_back(8'h3C);
    rise_q.delete();
    start_a(8'hA5, 1'b0, t0);
    exp_q_a.push_back('{data: 16'h003C, mosi: 8'hA5, cyc: t0 + 34});
    check("single_ncs_fall", ncs_a, 1'b0);
    check("single_busy_set", busy_a, 1'b1);
    wait_cyc(t0 + 34);
    check("single_ncs_rise_at_clko", ncs_a, 1'b1);
    wait_cyc(t0 + 35);
    check("single_busy_in_gap", busy_a, 1'b1);
    wait_cyc(t0 + 36);
    check("single_busy_clear", busy_a, 1'b0);
    check("single_rise_count", rise_q.size(), 8);
    if (rise_q.size() == 8)
      for (int k = 0; k < 8; k++) check("single_sclk_rise_cycle", rise_q[k], t0 + 2 + 4 * k);

    // Burst 01 (cont=1) then FE (cont=0)
    wait_cyc(cyc + 3);
    resp_q.push_back(8'h5A);
    resp_q.push_back(8'hC3);
    rise_q.delete();
    nr0 = ncs_rise_cnt;
    start_a(8'h01, 1'b1, t0);
    exp_q_a.push_back('{data: 16'h005A, mosi: 8'h01, cyc: t0 + 34});
    wait_cyc(t0 + 34);
    check("burst_ncs_held_in_wait", ncs_a, 1'b0);
    check("burst_busy_clear_in_wait", busy_a, 1'b0);
    start_a(8'hFE, 1'b0, t1);
    exp_q_a.push_back('{data: 16'h00C3, mosi: 8'hFE, cyc: t1 + 34});
    wait_cyc(t1 + 33);
    check("burst_no_ncs_rise_between", ncs_rise_cnt - nr0, 0);
    wait_cyc(t1 + 35);
    check("burst_ncs_rise_after_second", ncs_rise_cnt - nr0, 1);
    check("burst_rise_count", rise_q.size(), 16);
    wait_cyc(t1 + 40);

    // WAIT release by dropping cont without clki
    resp_q.push_back(8'h96);
    start_a(8'h69, 1'b1, t0);
    exp_q_a.push_back('{data: 16'h0096, mosi: 8'h69, cyc: t0 + 34});
    wait_cyc(t0 + 34);
    cont_a = 1'b0;
    check("wait_ncs_low_at_clko", ncs_a, 1'b0);
    wait_cyc(t0 + 35);
    check("wait_release_ncs", ncs_a, 1'b1);
    check("wait_release_busy", busy_a, 1'b1);
    wait_cyc(t0 + 36);
    check("wait_gap_busy", busy_a, 1'b1);
    wait_cyc(t0 + 37);
    check("wait_gap_done", busy_a, 1'b0);
    wait_cyc(t0 + 40);

    // clki while busy is ignored
    resp_q.push_back(8'h81);
    c0 = clko_cnt_a;
    start_a(8'h00, 1'b0, t0);
    exp_q_a.push_back('{data: 16'h0081, mosi: 8'h00, cyc: t0 + 34});
    pulse_a_ignored(t0 + 5);
    pulse_a_ignored(t0 + 18);
    pulse_a_ignored(t0 + 33);
    pulse_a_ignored(t0 + 35);
    wait_cyc(t0 + 40);
    check("busy_reject_clko_count", clko_cnt_a - c0, 1);
    check("busy_reject_idle_busy", busy_a, 1'b0);
    check("busy_reject_idle_ncs", ncs_a, 1'b1);

    // Reset mid-word after 3 SCLK rises
    resp_q.push_back(8'h77);
    rise_q.delete();
    c0 = clko_cnt_a;
    start_a(8'h5A, 1'b0, t0);
    guard = 0;
    while (rise_q.size() < 3 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("abort_reached_3_rises", rise_q.size() >= 3, 1'b1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("abort_ncs", ncs_a, 1'b1);
    check("abort_sclk", sclk_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_out", out_a, 8'h00);
    check("abort_clko", clko_a, 1'b0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    wait_cyc(cyc + 40);
    check("abort_no_clko", clko_cnt_a - c0, 0);
    resp_q.push_back(8'hE7);
    start_a(8'h18, 1'b0, t0);
    exp_q_a.push_back('{data: 16'h00E7, mosi: 8'h18, cyc: t0 + 34});
    wait_cyc(t0 + 37);
    check("after_abort_busy_clear", busy_a, 1'b0);

    // n=16, div=1 loopback
    start_b(16'hBEEF, t0);
    exp_q_b.push_back('{data: 16'hBEEF, mosi: 8'h00, cyc: t0 + 33});
    wait_cyc(t0 + 38);
    check("b_idle_after_word", busy_b, 1'b0);
    start_b(16'h8001, t0);
    exp_q_b.push_back('{data: 16'h8001, mosi: 8'h00, cyc: t0 + 33});
    wait_cyc(t0 + 38);

    check("a_pending_expectations", exp_q_a.size(), 0);
    check("b_pending_expectations", exp_q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
